// File: rtl/dm633_shifter_pkg.sv
// Shared definitions for the DM633 frame output stage.
package dm633_shifter_pkg;

    // DM633 PWM depth: bits shifted per channel
    localparam int c_bps          = 12;
    // two DM633 (16 channels each) per ledboard
    localparam int c_ch_per_board = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_GAP,
        S_LATCH
    } state_t;

endpackage

// File: rtl/dm633_shifter_if.sv
// Bus between the shifter, its framebuffer read port and the DM633 chain.
interface dm633_shifter_if #(
    parameter int c_addr_w = 10
);
    import dm633_shifter_pkg::*;

    logic                i_start;
    logic                o_ren;
    logic [c_addr_w-1:0] o_raddr;
    logic [c_bps-1:0]    i_data;
    logic                o_sdata;
    logic                o_sclk;
    logic                o_lat;
    logic                o_busy;
    logic                o_done;

    // controller side: requests frames and serves framebuffer reads
    modport master (
        output i_start,
        output i_data,
        input  o_ren,
        input  o_raddr,
        input  o_sdata,
        input  o_sclk,
        input  o_lat,
        input  o_busy,
        input  o_done
    );

    // shifter side
    modport slave (
        input  i_start,
        input  i_data,
        output o_ren,
        output o_raddr,
        output o_sdata,
        output o_sclk,
        output o_lat,
        output o_busy,
        output o_done
    );

endinterface

// File: rtl/dm633_shifter_bit_timer.sv
// Half-period timer for o_sclk: strobes on the last cycle of each
// SHIFT_LO / SHIFT_HI / GAP phase.
module dm633_shifter_bit_timer #(
    parameter int c_half = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic en,
    output logic phase_end
);

    localparam int                  c_cnt_w = (c_half > 1) ? $clog2(c_half) : 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(c_half - 1);

    logic [c_cnt_w-1:0] cnt;

    // count cycles within a phase; wrapping at the strobe lets LO/HI phases follow back-to-back
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == c_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + c_cnt_w'(1);
        end
    end

    assign phase_end = en && (cnt == c_last);

endmodule

// File: rtl/dm633_shifter.sv
// DM633 frame output stage: reads all channels from the framebuffer (highest
// address first), shifts each 12-bit word MSB-first onto the daisy chain and
// finishes the frame with one latch pulse.
module dm633_shifter
    import dm633_shifter_pkg::*;
#(
    parameter int c_ledboards = 30,
    parameter int c_half      = 2,
    parameter int c_lat_w     = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    dm633_shifter_if.slave bus
);

    localparam int c_channels = c_ledboards * c_ch_per_board;
    localparam int c_addr_w   = $clog2(c_channels);
    localparam int c_bit_w    = $clog2(c_bps);
    localparam int c_lat_cw   = (c_lat_w > 1) ? $clog2(c_lat_w) : 1;

    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);
    localparam logic [c_bit_w-1:0]  c_top_bit   = c_bit_w'(c_bps - 1);
    localparam logic [c_lat_cw-1:0] c_lat_last  = c_lat_cw'(c_lat_w - 1);

    state_t              state;
    logic [c_addr_w-1:0] raddr;
    logic [c_bit_w-1:0]  bit_cnt;
    logic [c_bps-1:0]    shreg;
    logic [c_lat_cw-1:0] lat_cnt;
    logic                ren;
    logic                sdata;
    logic                sclk;
    logic                lat;
    logic                busy;
    logic                done;
    logic                timer_en;
    logic                phase_end;

    assign timer_en = (state == S_SHIFT_LO) || (state == S_SHIFT_HI) || (state == S_GAP);

    dm633_shifter_bit_timer #(
        .c_half    (c_half)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .en        (timer_en),
        .phase_end (phase_end)
    );

    // frame sequencer; every output is set together with the state it belongs to
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            raddr   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            lat_cnt <= '0;
            ren     <= 1'b0;
            sdata   <= 1'b0;
            sclk    <= 1'b0;
            lat     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ren  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state <= S_FETCH;
                        ren   <= 1'b1;
                        raddr <= c_last_addr;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shreg   <= bus.i_data;
                    bit_cnt <= c_top_bit;
                    sdata   <= bus.i_data[c_bps-1];
                    sclk    <= 1'b0;
                    state   <= S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    if (phase_end) begin
                        sclk  <= 1'b1;
                        state <= S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    if (phase_end) begin
                        sclk <= 1'b0;
                        if (bit_cnt != '0) begin
                            shreg   <= {shreg[c_bps-2:0], 1'b0};
                            sdata   <= shreg[c_bps-2];
                            bit_cnt <= bit_cnt - c_bit_w'(1);
                            state   <= S_SHIFT_LO;
                        end else if (raddr != '0) begin
                            raddr <= raddr - c_addr_w'(1);
                            ren   <= 1'b1;
                            state <= S_FETCH;
                        end else begin
                            sdata <= 1'b0;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (phase_end) begin
                        lat     <= 1'b1;
                        lat_cnt <= '0;
                        state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (lat_cnt == c_lat_last) begin
                        lat   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + c_lat_cw'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ren   = ren;
    assign bus.o_raddr = raddr;
    assign bus.o_sdata = sdata;
    assign bus.o_sclk  = sclk;
    assign bus.o_lat   = lat;
    assign bus.o_busy  = busy;
    assign bus.o_done  = done;

endmodule

// File: tb/tb_dm633_shifter.sv
// Bench for dm633_shifter: one board (32 channels), latch width 2, two
// instances with sclk half-periods of 1 and 3 cycles.
module tb_dm633_shifter;
    import dm633_shifter_pkg::*;

    localparam int NCH   = c_ch_per_board;
    localparam int AW    = 5;
    localparam int LATW  = 2;
    localparam int NBIT  = NCH * c_bps;
    localparam int RXMAX = NBIT + 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic             start [2];
    logic [c_bps-1:0] fb    [2][NCH];
    logic [AW+5:0]    outs  [2];
    logic             rx    [2][RXMAX];

    int rx_n [2], glitch [2], width_err [2], lat_err [2], lat_cnt [2];
    int done_cnt [2], ren_cnt [2], addr_err [2];
    int first_ren_cyc [2], first_ren_busy [2], first_rise_cyc [2];
    int done_cyc [2], done_busy [2], done_sdata [2];

    int n_checks = 0;
    int n_errors = 0;

    dm633_shifter_if #(.c_addr_w(AW)) bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int H = (g == 0) ? 1 : 3;

        int   hi_run  = 0;
        int   lo_run  = 0;
        int   lat_run = 0;
        logic p_sclk  = 1'b0;
        logic p_sdata = 1'b0;
        logic p_lat   = 1'b0;

        dm633_shifter #(
            .c_ledboards (1),
            .c_half      (H),
            .c_lat_w     (LATW)
        ) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus[g])
        );

        assign bus[g].i_start = start[g];
        assign outs[g] = {bus[g].o_ren, bus[g].o_raddr, bus[g].o_sdata, bus[g].o_sclk,
                          bus[g].o_lat, bus[g].o_busy, bus[g].o_done};

        // framebuffer with registered read port
        always @(posedge clk) if (bus[g].o_ren) bus[g].i_data <= fb[g][bus[g].o_raddr];

        // observe the chain side once per cycle
        always @(negedge clk) begin
            if (!rst_n) begin
                p_sclk = 1'b0; p_sdata = 1'b0; p_lat = 1'b0;
                hi_run = 0; lo_run = 0; lat_run = 0;
            end else begin
                if (bus[g].o_ren) begin
                    if (first_ren_cyc[g] < 0) begin
                        first_ren_cyc[g]  = cyc;
                        first_ren_busy[g] = int'(bus[g].o_busy);
                    end
                    if (int'(bus[g].o_raddr) != NCH - 1 - ren_cnt[g]) addr_err[g]++;
                    ren_cnt[g]++;
                end
                if (bus[g].o_sclk && !p_sclk) begin
                    if (rx_n[g] == 0) first_rise_cyc[g] = cyc;
                    else if (lo_run != H && lo_run != H + 2) width_err[g]++;
                    if (rx_n[g] < RXMAX) rx[g][rx_n[g]] = bus[g].o_sdata;
                    rx_n[g]++;
                    if (bus[g].o_sdata !== p_sdata) glitch[g]++;
                end
                if (bus[g].o_sclk && p_sclk && bus[g].o_sdata !== p_sdata) glitch[g]++;
                if (bus[g].o_sclk) begin
                    hi_run++;
                    lo_run = 0;
                end else begin
                    if (p_sclk && hi_run != H) width_err[g]++;
                    hi_run = 0;
                    lo_run++;
                end
                if (bus[g].o_lat) begin
                    lat_run++;
                    if (bus[g].o_sclk) lat_err[g]++;
                end else begin
                    if (p_lat) begin
                        lat_cnt[g]++;
                        if (lat_run != LATW) width_err[g]++;
                    end
                    lat_run = 0;
                end
                if (bus[g].o_done) begin
                    done_cnt[g]++;
                    done_cyc[g]   = cyc;
                    done_busy[g]  = int'(bus[g].o_busy);
                    done_sdata[g] = int'(bus[g].o_sdata);
                end
                p_sclk  = bus[g].o_sclk;
                p_sdata = bus[g].o_sdata;
                p_lat   = bus[g].o_lat;
            end
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr(input int g);
        rx_n[g] = 0; glitch[g] = 0; width_err[g] = 0; lat_err[g] = 0;
        lat_cnt[g] = 0; done_cnt[g] = 0; ren_cnt[g] = 0; addr_err[g] = 0;
        first_ren_cyc[g] = -1; first_ren_busy[g] = -1; first_rise_cyc[g] = -1;
        done_cyc[g] = -1; done_busy[g] = -1; done_sdata[g] = -1;
    endtask

    // 0: a*0x81, 1: random, 2: all ones, 3: alternating 0xAAA/0x555
    task automatic fill(input int g, input int mode);
        for (int a = 0; a < NCH; a++) begin
            case (mode)
                0:       fb[g][a] = c_bps'(a * 'h81);
                1:       fb[g][a] = c_bps'($urandom);
                2:       fb[g][a] = 12'hFFF;
                default: fb[g][a] = (a % 2 == 0) ? 12'hAAA : 12'h555;
            endcase
        end
    endtask

    task automatic start_frame(input int g, output int c0);
        @(posedge clk);
        #1;
        start[g] = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (done_cnt[g] == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_seen", longint'(done_cnt[g] != 0), 1);
    endtask

    // compare the captured serial stream and frame timing against the frame rules
    task automatic verify_frame(input int g, input int c0, input string tag);
        int h   = (g == 0) ? 1 : 3;
        int bad = 0;
        logic [c_bps-1:0] w;
        check({tag, ".nbits"}, rx_n[g], NBIT);
        for (int c = 0; c < NCH; c++) begin
            w = '0;
            for (int b = 0; b < c_bps; b++) begin
                if (c * c_bps + b < RXMAX) w = {w[c_bps-2:0], rx[g][c * c_bps + b]};
            end
            if (w !== fb[g][NCH - 1 - c]) bad++;
        end
        check({tag, ".bad_words"}, bad, 0);
        check({tag, ".ren_cyc"}, first_ren_cyc[g], c0 + 1);
        check({tag, ".ren_busy"}, first_ren_busy[g], 1);
        check({tag, ".rise_cyc"}, first_rise_cyc[g], c0 + 3 + h);
        check({tag, ".done_cyc"}, done_cyc[g], c0 + 1 + NCH * (2 + c_bps * 2 * h) + h + LATW);
        check({tag, ".done_busy"}, done_busy[g], 0);
        check({tag, ".done_sdata"}, done_sdata[g], 0);
        check({tag, ".lat_pulses"}, lat_cnt[g], 1);
        check({tag, ".done_pulses"}, done_cnt[g], 1);
        check({tag, ".reads"}, ren_cnt[g], NCH);
        check({tag, ".addr_order"}, addr_err[g], 0);
        check({tag, ".glitch"}, glitch[g], 0);
        check({tag, ".widths"}, width_err[g], 0);
        check({tag, ".sclk_in_lat"}, lat_err[g], 0);
    endtask

    initial begin
        int c0;
        int n;
        start[0] = 1'b0;
        start[1] = 1'b0;
        fill(0, 0);
        fill(1, 0);
        clr(0);
        clr(1);

        repeat (3) @(posedge clk);
        #1;
        check("rst.outs0", outs[0], 0);
        check("rst.outs1", outs[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle.outs0", outs[0], 0);

        // slow sclk instance, random words
        fill(1, 1);
        clr(1);
        start_frame(1, c0);
        wait_done(1, 3000);
        verify_frame(1, c0, "h3");

        // indexed pattern
        fill(0, 0);
        clr(0);
        start_frame(0, c0);
        wait_done(0, 1200);
        verify_frame(0, c0, "idx");

        // random words with stray start requests while busy
        fill(0, 1);
        clr(0);
        start_frame(0, c0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(5, 190)) @(posedge clk);
            #1;
            start[0] = 1'b1;
            @(posedge clk);
            #1;
            start[0] = 1'b0;
        end
        wait_done(0, 1200);
        verify_frame(0, c0, "rnd");
        repeat (4) @(negedge clk);
        #1;
        check("rnd.idle_outs", outs[0], 0);
        check("rnd.idle_reads", ren_cnt[0], NCH);

        // all ones, then next frame requested in the done cycle
        fill(0, 2);
        clr(0);
        start_frame(0, c0);
        wait_done(0, 1200);
        verify_frame(0, c0, "ones");
        fill(0, 3);
        clr(0);
        start[0] = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_done(0, 1200);
        verify_frame(0, c0, "alt");

        // reset in the middle of channel 10
        fill(0, 1);
        clr(0);
        start_frame(0, c0);
        n = 0;
        while (rx_n[0] < 10 * c_bps + 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst.reached", longint'(rx_n[0] >= 10 * c_bps + 6), 1);
        #4;
        rst_n = 1'b0;
        #1;
        check("rst.mid_outs", outs[0], 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst.held_outs", outs[0], 0);
        check("rst.no_lat", lat_cnt[0], 0);
        check("rst.no_done", done_cnt[0], 0);
        rst_n = 1'b1;

        fill(0, 1);
        clr(0);
        start_frame(0, c0);
        wait_done(0, 1200);
        verify_frame(0, c0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
